// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
//
// Drives one keypad column low at a time (one-cold), samples the
// synchronized rows once per scan tick and runs a four-state FSM that
// debounces both the press and the release of a single key.
//
// Ports
//   clk       : system clock, all logic on posedge
//   rst_n     : asynchronous active-low reset
//   row_in    : keypad rows, active-low, asynchronous to clk
//   col_out   : column drive, the selected column is 0
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-clk pulse when a press is accepted
//   key_held  : high from press acceptance until release acceptance
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  // two-flop row synchronizer, idle level is all ones
  logic [3:0]       r_rows_m, r_rows_s;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  state_t           r_state, w_state_n;
  logic [1:0]       r_col, w_col_n;
  logic [1:0]       r_cand_row, w_cand_row_n;
  logic [1:0]       r_cand_col, w_cand_col_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [3:0]       r_code, w_code_n;
  logic             r_valid, w_valid_n;
  logic             r_held, w_held_n;

  logic             w_idle, w_single;
  logic [1:0]       w_row_idx;
  logic             w_cnt_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_m <= 4'hF;
      r_rows_s <= 4'hF;
    end else begin
      r_rows_m <= row_in;
      r_rows_s <= r_rows_m;
    end
  end

  // prescaler: 0..SCAN_DIV-1, tick on the terminal count
  assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // sample classification: exactly one low row is a usable press
  always_comb begin
    w_idle    = (r_rows_s == 4'b1111);
    w_single  = 1'b1;
    w_row_idx = 2'd0;
    case (r_rows_s)
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_single  = 1'b0;
    endcase
  end

  assign w_cnt_full = (r_cnt == CNT_W'(DEBOUNCE_SCANS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SCAN;
      r_col      <= 2'd0;
      r_cand_row <= 2'd0;
      r_cand_col <= 2'd0;
      r_cnt      <= '0;
      r_code     <= 4'd0;
      r_valid    <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_col      <= w_col_n;
      r_cand_row <= w_cand_row_n;
      r_cand_col <= w_cand_col_n;
      r_cnt      <= w_cnt_n;
      r_code     <= w_code_n;
      r_valid    <= w_valid_n;
      r_held     <= w_held_n;
    end
  end

  // The full-count checks sit ahead of the tick checks so acceptance
  // happens on the clk after the count fills, even when SCAN_DIV is 1.
  // The count can therefore never be incremented past DEBOUNCE_SCANS.
  always_comb begin
    w_state_n    = r_state;
    w_col_n      = r_col;
    w_cand_row_n = r_cand_row;
    w_cand_col_n = r_cand_col;
    w_cnt_n      = r_cnt;
    w_code_n     = r_code;
    w_valid_n    = 1'b0;
    w_held_n     = r_held;
    case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (w_single) begin
            w_cand_row_n = w_row_idx;
            w_cand_col_n = r_col;
            w_cnt_n      = CNT_W'(1);
            w_state_n    = DEBOUNCE;
          end else begin
            w_col_n = r_col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (w_cnt_full) begin
          w_code_n  = {r_cand_row, r_cand_col};
          w_valid_n = 1'b1;
          w_held_n  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = HELD;
        end else if (w_tick) begin
          if (w_single && (w_row_idx == r_cand_row)) begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end else begin
            w_cnt_n   = '0;
            w_col_n   = r_col + 2'd1;
            w_state_n = SCAN;
          end
        end
      end
      HELD: begin
        if (w_tick && w_idle) begin
          w_cnt_n   = CNT_W'(1);
          w_state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (w_cnt_full) begin
          w_held_n  = 1'b0;
          w_cnt_n   = '0;
          w_col_n   = r_col + 2'd1;
          w_state_n = SCAN;
        end else if (w_tick) begin
          if (w_idle) begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end else begin
            w_cnt_n   = '0;
            w_state_n = HELD;
          end
        end
      end
      default: begin
        w_state_n = SCAN;
        w_cnt_n   = '0;
      end
    endcase
  end

  assign col_out   = ~(4'b0001 << r_col);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000: clk cycles per scan tick (1 kHz at 100 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 20: consecutive matching scan-tick samples needed to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1: 100 MHz system clock; all logic on posedge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port row_in, input, 4: keypad rows, active-low with external pull-ups, asynchronous to clk.
REQ-006 The block SHALL have port col_out, output, 4: keypad column drive, one-cold (the driven column is 0).
REQ-007 The block SHALL have port key_code, output, 4: code of the last accepted key, equal to row_idx*4 + col_idx.
REQ-008 The block SHALL have port key_valid, output, 1: single-clk pulse when a new key press is accepted.
REQ-009 The block SHALL have port key_held, output, 1: level, high from acceptance of a press until acceptance of its release.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rows_s.
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan_tick SHALL be high for one clk when the count equals SCAN_DIV-1.
REQ-012 A sample SHALL be rows_s taken on a scan_tick cycle; it reflects the column driven during the preceding tick period.
REQ-013 A sample SHALL be "single" when exactly one bit is 0, giving row_idx = the index of that bit; it SHALL be "idle" when it is 4'b1111; otherwise it SHALL be "multi".
REQ-014 The FSM SHALL have four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: on each scan_tick, a single sample SHALL latch cand_row and cand_col=col_idx, set the debounce count to 1, and go to DEBOUNCE without advancing the column; an idle or multi sample SHALL advance col_idx by 1, wrapping 3->0.
REQ-016 DEBOUNCE: the column SHALL stay frozen; each scan_tick whose sample is single with the same row_idx SHALL increment the count; any other sample SHALL clear the count, advance the column and return to SCAN with no pulse.
REQ-017 When the count reaches DEBOUNCE_SCANS, the block SHALL, in the next clk cycle, drive key_code={cand_row,cand_col[1:0]} as row*4+col, assert key_valid for exactly one cycle, set key_held=1, and enter HELD.
REQ-018 HELD: the column SHALL stay frozen; an idle sample on a scan_tick SHALL set the release count to 1 and go to RELEASE; any non-idle sample (including a different row or multi) SHALL keep HELD with no new pulse.
REQ-019 RELEASE: each idle sample SHALL increment the release count; any non-idle sample SHALL return to HELD; at DEBOUNCE_SCANS the block SHALL clear key_held, advance the column and go to SCAN.
REQ-020 key_code SHALL hold its value until the next accepted press; key_valid SHALL never assert in consecutive cycles or outside the DEBOUNCE->HELD transition.
REQ-021 col_out SHALL equal ~(4'b0001 << col_idx) at all times.
REQ-022 Counter widths SHALL be sized to hold SCAN_DIV-1 and DEBOUNCE_SCANS without overflow.

Reset
REQ-023 While rst_n=0, outputs SHALL be col_out=4'b1110, key_code=0, key_valid=0, key_held=0; internally state=SCAN, col_idx=0, and all counters and synchronizers cleared (synchronizer flops to 4'b1111).
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort the operation immediately, with no key_valid pulse on or after deassertion.
REQ-025 After rst_n rises, the first scan_tick SHALL occur SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-026 Idle rows 4'b1111 for 40 clk -> col_out cycles 1110,1101,1011,0111,1110 every 4 clk; key_valid never asserts.
REQ-027 Row 2 pulled low only while col_out=1101 (col 1), held stable -> exactly one key_valid pulse with key_code=9, key_held=1, col_out frozen at 1101.
REQ-028 Key code 9 then release for 3 idle ticks -> key_held falls, scanning resumes at col 2; a 1-tick bounce back to low during release -> key_held stays 1.
REQ-029 Press lasting 2 ticks (bounce) -> no key_valid, column advances, key_code unchanged.
REQ-030 Two rows low simultaneously (rows=4'b0011) -> treated as multi, no acceptance; rst_n pulsed low during DEBOUNCE of key 5 -> outputs return to reset values and no pulse appears.
